// File: rtl/icache_line.sv
// Direct-mapped instruction cache with multi-word lines and burst line refill.
// Hits return data in the same cycle; misses stall fetch until the whole line is refilled.
module icache_line #(
  parameter int unsigned INDEX_BITS  = 7,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_sram_stall,
  output logic        inst_cache_req,
  output logic [31:0] inst_cache_addr,
  input  logic [31:0] inst_cache_rdata,
  input  logic        inst_cache_dok,
  input  logic        invalidate
);

  localparam int unsigned TAG_BITS  = 30 - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned LINE_BITS = TAG_BITS + INDEX_BITS;
  localparam int unsigned NUM_LINES = 1 << INDEX_BITS;
  localparam int unsigned NUM_WORDS = 1 << (INDEX_BITS + OFFSET_BITS);

  typedef enum logic {
    IDLE,
    REFILL
  } state_e;

  state_e                 state_q, state_d;
  logic [LINE_BITS-1:0]   line_q, line_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic                   kill_q, kill_d;
  logic                   req_q, req_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;

  logic [TAG_BITS-1:0]    tag_mem  [NUM_LINES];
  logic [31:0]            data_mem [NUM_WORDS];

  logic [TAG_BITS-1:0]    addr_tag;
  logic [INDEX_BITS-1:0]  addr_idx;
  logic [OFFSET_BITS-1:0] addr_off;
  logic [TAG_BITS-1:0]    line_tag;
  logic [INDEX_BITS-1:0]  line_idx;
  logic                   hit;
  logic                   tag_we;
  logic                   data_we;
  logic                   unused_addr_bits;

  assign addr_tag         = inst_sram_addr[31 -: TAG_BITS];
  assign addr_idx         = inst_sram_addr[OFFSET_BITS + 2 +: INDEX_BITS];
  assign addr_off         = inst_sram_addr[2 +: OFFSET_BITS];
  assign unused_addr_bits = ^inst_sram_addr[1:0];
  assign line_tag         = line_q[LINE_BITS-1 -: TAG_BITS];
  assign line_idx         = line_q[INDEX_BITS-1:0];

  // Combinational lookup against the asynchronous-read arrays
  assign hit             = inst_sram_en & valid_q[addr_idx] & (tag_mem[addr_idx] == addr_tag);
  assign inst_sram_rdata = data_mem[{addr_idx, addr_off}];
  assign inst_sram_stall = (state_q == REFILL) | (inst_sram_en & ~hit);

  assign inst_cache_req  = req_q;
  assign inst_cache_addr = {line_q, {(OFFSET_BITS + 2){1'b0}}};

  // Next-state, refill bookkeeping and array write enables
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    valid_d = valid_q;
    tag_we  = 1'b0;
    data_we = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (inst_sram_en && !hit && !invalidate) begin
          line_d            = {addr_tag, addr_idx};
          cnt_d             = '0;
          valid_d[addr_idx] = 1'b0;
          kill_d            = 1'b0;
          state_d           = REFILL;
        end
      end
      REFILL: begin
        if (invalidate) begin
          kill_d = 1'b1;
        end
        if (inst_cache_dok) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + OFFSET_BITS'(1);
          if (cnt_q == '1) begin
            tag_we = 1'b1;
            if (!kill_q && !invalidate) begin
              valid_d[line_idx] = 1'b1;
            end
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Flash invalidate overrides any valid bit set this cycle
    if (invalidate) begin
      valid_d = '0;
    end
  end

  assign req_d = (state_d == REFILL);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      line_q  <= '0;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      req_q   <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays are not reset
  always_ff @(posedge clk) begin
    if (resetn && tag_we) begin
      tag_mem[line_idx] <= line_tag;
    end
    if (resetn && data_we) begin
      data_mem[{line_idx, cnt_q}] <= inst_cache_rdata;
    end
  end

endmodule

// File: tb/tb_icache_line.sv
// Directed bench for icache_line: refill timing, hits, eviction, gapped beats,
// invalidate and reset interactions.
module tb_icache_line;

  logic        clk;
  logic        resetn;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_stall;
  logic        inst_cache_req;
  logic [31:0] inst_cache_addr;
  logic [31:0] inst_cache_rdata;
  logic        inst_cache_dok;
  logic        invalidate;

  int checks   = 0;
  int failures = 0;
  int n;

  icache_line dut (
    .clk              (clk),
    .resetn           (resetn),
    .inst_sram_en     (inst_sram_en),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_rdata  (inst_sram_rdata),
    .inst_sram_stall  (inst_sram_stall),
    .inst_cache_req   (inst_cache_req),
    .inst_cache_addr  (inst_cache_addr),
    .inst_cache_rdata (inst_cache_rdata),
    .inst_cache_dok   (inst_cache_dok),
    .invalidate       (invalidate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input logic [31:0] a);
    inst_sram_addr = a;
    #1;
  endtask

  // Drives four beats, optionally with idle gaps and an invalidate pulse on one beat;
  // returns the number of cycles req was seen high.
  task automatic do_refill(input logic [31:0] base, input int gap, input int inv_beat,
                           output int req_cycles);
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        inst_cache_dok = 1'b0;
        if (inst_cache_req) req_cycles++;
        step();
      end
      inst_cache_dok   = 1'b1;
      inst_cache_rdata = base + 32'(i);
      invalidate       = (i == inv_beat);
      if (inst_cache_req) req_cycles++;
      step();
    end
    inst_cache_dok = 1'b0;
    invalidate     = 1'b0;
  endtask

  initial begin
    resetn           = 1'b0;
    inst_sram_en     = 1'b1;
    inst_sram_addr   = 32'h0;
    inst_cache_rdata = 32'h0;
    inst_cache_dok   = 1'b0;
    invalidate       = 1'b0;

    // Reset
    step();
    step();
    chk("rst_req", 32'(inst_cache_req), 32'h0);
    chk("rst_stall", 32'(inst_sram_stall), 32'h1);
    chk("rst_caddr", inst_cache_addr, 32'h0);
    resetn = 1'b1;
    step();
    chk("rst_refill_req", 32'(inst_cache_req), 32'h1);
    chk("rst_refill_caddr", inst_cache_addr, 32'h0);
    do_refill(32'h10, 0, -1, n);
    chk("rst_refill_cycles", 32'(n), 32'd4);
    chk("rst_hit_stall", 32'(inst_sram_stall), 32'h0);
    chk("rst_hit_data", inst_sram_rdata, 32'h10);

    // Cold miss then hits
    set_addr(32'h1004);
    chk("cold_stall", 32'(inst_sram_stall), 32'h1);
    chk("cold_req_t", 32'(inst_cache_req), 32'h0);
    step();
    chk("cold_req", 32'(inst_cache_req), 32'h1);
    chk("cold_caddr", inst_cache_addr, 32'h1000);
    do_refill(32'hA0, 0, -1, n);
    chk("cold_cycles", 32'(n), 32'd4);
    chk("cold_req_done", 32'(inst_cache_req), 32'h0);
    chk("hit_1004_stall", 32'(inst_sram_stall), 32'h0);
    chk("hit_1004", inst_sram_rdata, 32'hA1);
    set_addr(32'h1000);
    chk("hit_1000", inst_sram_rdata, 32'hA0);
    set_addr(32'h1008);
    chk("hit_1008", inst_sram_rdata, 32'hA2);
    set_addr(32'h100C);
    chk("hit_100c", inst_sram_rdata, 32'hA3);
    chk("hit_100c_stall", 32'(inst_sram_stall), 32'h0);

    // Conflict eviction
    set_addr(32'h1804);
    chk("evict_stall", 32'(inst_sram_stall), 32'h1);
    step();
    chk("evict_caddr", inst_cache_addr, 32'h1800);
    do_refill(32'hB0, 0, -1, n);
    chk("evict_data", inst_sram_rdata, 32'hB1);
    set_addr(32'h1004);
    chk("evict_old_miss", 32'(inst_sram_stall), 32'h1);
    step();
    chk("evict_old_caddr", inst_cache_addr, 32'h1000);

    // Gapped beats
    do_refill(32'hC0, 1, -1, n);
    chk("gap_cycles", 32'(n), 32'd8);
    chk("gap_data1", inst_sram_rdata, 32'hC1);
    set_addr(32'h100C);
    chk("gap_data3", inst_sram_rdata, 32'hC3);

    // Invalidate mid-refill
    set_addr(32'h2010);
    step();
    chk("inv_mid_caddr", inst_cache_addr, 32'h2010);
    do_refill(32'hD0, 0, 2, n);
    chk("inv_mid_cycles", 32'(n), 32'd4);
    chk("inv_mid_req", 32'(inst_cache_req), 32'h0);
    chk("inv_mid_miss", 32'(inst_sram_stall), 32'h1);
    step();
    chk("inv_mid_rereq", 32'(inst_cache_req), 32'h1);
    do_refill(32'hD8, 0, -1, n);
    set_addr(32'h2014);
    chk("inv_mid_hit_stall", 32'(inst_sram_stall), 32'h0);
    chk("inv_mid_hit", inst_sram_rdata, 32'hD9);
    set_addr(32'h1004);
    chk("inv_flushed_other", 32'(inst_sram_stall), 32'h1);

    // Invalidate coincident with last beat
    set_addr(32'h3020);
    step();
    do_refill(32'hE0, 0, 3, n);
    chk("inv_last_req", 32'(inst_cache_req), 32'h0);
    chk("inv_last_miss", 32'(inst_sram_stall), 32'h1);
    step();
    chk("inv_last_rereq", 32'(inst_cache_req), 32'h1);
    do_refill(32'hE8, 0, -1, n);
    set_addr(32'h3028);
    chk("inv_last_hit", inst_sram_rdata, 32'hEA);
    chk("inv_last_hit_stall", 32'(inst_sram_stall), 32'h0);

    // Reset mid-refill
    set_addr(32'h4030);
    step();
    for (int i = 0; i < 2; i++) begin
      inst_cache_dok   = 1'b1;
      inst_cache_rdata = 32'h55 + 32'(i);
      step();
    end
    inst_cache_dok = 1'b0;
    resetn = 1'b0;
    step();
    chk("rmid_req", 32'(inst_cache_req), 32'h0);
    resetn = 1'b1;
    #1;
    chk("rmid_miss", 32'(inst_sram_stall), 32'h1);
    step();
    chk("rmid_caddr", inst_cache_addr, 32'h4030);
    do_refill(32'hF0, 0, -1, n);
    chk("rmid_cycles", 32'(n), 32'd4);
    set_addr(32'h403C);
    chk("rmid_hit", inst_sram_rdata, 32'hF3);

    // en=0 and stray dok while idle
    inst_sram_en = 1'b0;
    #1;
    chk("en0_stall", 32'(inst_sram_stall), 32'h0);
    inst_cache_dok   = 1'b1;
    inst_cache_rdata = 32'hDEAD;
    step();
    inst_cache_dok = 1'b0;
    chk("en0_no_req", 32'(inst_cache_req), 32'h0);
    inst_sram_en = 1'b1;
    set_addr(32'h4030);
    chk("stray_dok_data", inst_sram_rdata, 32'hF0);
    chk("stray_dok_stall", 32'(inst_sram_stall), 32'h0);

    // Back-to-back misses
    set_addr(32'h5040);
    step();
    do_refill(32'h70, 0, -1, n);
    set_addr(32'h6050);
    chk("b2b_gap_req", 32'(inst_cache_req), 32'h0);
    step();
    chk("b2b_req", 32'(inst_cache_req), 32'h1);
    chk("b2b_caddr", inst_cache_addr, 32'h6050);
    do_refill(32'h80, 0, -1, n);
    chk("b2b_hit", inst_sram_rdata, 32'h80);
    set_addr(32'h5048);
    chk("b2b_prev_hit", inst_sram_rdata, 32'h72);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
